fg_spi_cfg_loader: RTL and testbench

SPI-slave front end for the function generator's 7 × 8-bit configuration register bank. It lives in the top level, upstream of the config registers. It converts 16-bit SPI frames into single-cycle register write strobes (address + data), so the parallel ui_in/uio_in write path can be replaced by a 3-pin serial interface. It also supports readback of any config register over MISO.

---
 rtl/fg_pkg.sv | 21 ++
 rtl/fg_synchronizer.sv | 36 +++
 rtl/fg_spi_cfg_loader.sv | 215 +++++++++++++++++++++
 tb/tb_fg_spi_cfg_loader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fg_pkg.sv
// ---------------------------------------------------------------------------
// fg_pkg
// Shared constants for the function generator's SPI configuration path:
// SPI frame geometry and the loader FSM state encoding.
// ---------------------------------------------------------------------------
package fg_pkg;

  // A frame is a command byte followed by a data byte, MSB first.
  localparam int FG_SPI_FRAME_BITS = 16;
  // Position of the read/write flag within the full frame.
  localparam int FG_SPI_RW_BIT     = 15;
  // Width of the per-frame bit counter.
  localparam int FG_SPI_CNT_W      = $clog2(FG_SPI_FRAME_BITS);

  // Loader FSM encoding.
  localparam logic [1:0] FG_ST_IDLE = 2'd0;  // waiting for chip select
  localparam logic [1:0] FG_ST_CMD  = 2'd1;  // shifting in the command byte
  localparam logic [1:0] FG_ST_DATA = 2'd2;  // shifting in / out the data byte
  localparam logic [1:0] FG_ST_HOLD = 2'd3;  // frame done, waiting for cs_n high

endpackage

// File: rtl/fg_synchronizer.sv
// ---------------------------------------------------------------------------
// FG_Synchronizer
// Multi-flop synchronizer bringing a single asynchronous bit into the clk
// domain. STAGES must be at least 2.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous, active-low reset; loads RST_VAL into every stage
//   d      asynchronous input
//   q      synchronized output (STAGES clk cycles of latency)
// ---------------------------------------------------------------------------
module FG_Synchronizer #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] pipe;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= {STAGES{RST_VAL}};
    end else begin
      pipe <= {pipe[STAGES-2:0], d};
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/fg_spi_cfg_loader.sv
// ---------------------------------------------------------------------------
// fg_spi_cfg_loader
// SPI-slave (mode 0) front end for the 7 x 8-bit configuration register bank.
// A 16-bit frame {rw, 4'b0000, addr[2:0], data[7:0]} becomes a single-cycle
// write strobe (rw=1) or a register readback over MISO (rw=0).
//
// Ports:
//   clk          system clock
//   rst_n        synchronous, active-low reset
//   sclk_i       SPI clock (async, CPOL=0, CPHA=0)
//   cs_n_i       SPI chip select (async, active low)
//   mosi_i       SPI data in (async, MSB first)
//   miso_o       SPI data out (registered, MSB first)
//   cfg_rdata_i  contents of register cfg_addr_o from the register bank
//   cfg_addr_o   target address, held from command byte to next command byte
//   cfg_data_o   write data, valid while cfg_wr_o is high
//   cfg_wr_o     one-clk write strobe
//   busy_o       frame in progress (command or data phase)
//   err_o        sticky error: aborted frame or write to invalid address;
//                cleared by reset or a valid write frame
// ---------------------------------------------------------------------------
module fg_spi_cfg_loader
  import fg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 7,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] cfg_rdata_i,
  output logic [ADDR_W-1:0] cfg_addr_o,
  output logic [DATA_W-1:0] cfg_data_o,
  output logic              cfg_wr_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_W = FG_SPI_CNT_W;
  // The rw flag is the first bit of the command byte, so once the command
  // byte is fully shifted in it sits at this position of the shift word.
  localparam int RW_CMD_POS = FG_SPI_RW_BIT - DATA_W;

  localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FG_SPI_FRAME_BITS - 1);
  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(NUM_REGS);

  // -------------------------------------------------------------------------
  // Input synchronization and edge detection
  // -------------------------------------------------------------------------
  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;

  FG_Synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk_i),
    .q     (sclk_s)
  );

  // NOTE: cs_n resets to "asserted" rather than idle-high. If reset lands in
  // the middle of a frame, the still-low pin then produces no falling edge, so
  // the rest of that frame is ignored until cs_n goes high and low again. A
  // rise seen right after reset is harmless in IDLE.
  FG_Synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n_i),
    .q     (cs_n_s)
  );

  FG_Synchronizer #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi_i),
    .q     (mosi_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;

  // -------------------------------------------------------------------------
  // Frame FSM and datapath
  // -------------------------------------------------------------------------
  logic [1:0]        state_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-2:0] shift_q;    // only the bits still needed for the next byte
  logic [DATA_W-1:0] shift_next; // byte as it looks after the current rise
  logic [DATA_W-1:0] tx_q;
  logic              rw_q;
  logic              load_tx_q;  // one-cycle delay so cfg_rdata_i follows cfg_addr_o
  logic              addr_valid;

  assign shift_next = {shift_q, mosi_s};
  assign addr_valid = ({1'b0, cfg_addr_o} < ADDR_LIMIT);
  assign busy_o     = (state_q == FG_ST_CMD) || (state_q == FG_ST_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FG_ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      load_tx_q  <= 1'b0;
      miso_o     <= 1'b0;
      cfg_addr_o <= '0;
      cfg_data_o <= '0;
      cfg_wr_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      cfg_wr_o  <= 1'b0;
      load_tx_q <= 1'b0;

      case (state_q)
        FG_ST_IDLE: begin
          miso_o <= 1'b0;
          if (cs_fall) begin
            state_q <= FG_ST_CMD;
            // A first sclk rise seen together with the cs edge still counts.
            if (sclk_rise) begin
              shift_q   <= shift_next[DATA_W-2:0];
              bit_cnt_q <= CNT_W'(1);
            end else begin
              shift_q   <= '0;
              bit_cnt_q <= '0;
            end
          end
        end

        FG_ST_CMD: begin
          miso_o <= 1'b0;
          if (cs_rise) begin
            state_q <= FG_ST_IDLE;
            err_o   <= 1'b1;
          end else if (sclk_rise) begin
            shift_q   <= shift_next[DATA_W-2:0];
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == CMD_LAST) begin
              rw_q       <= ~shift_next[RW_CMD_POS];  // rw=0 means read
              cfg_addr_o <= shift_next[ADDR_W-1:0];
              load_tx_q  <= 1'b1;
              state_q    <= FG_ST_DATA;
            end
          end
        end

        FG_ST_DATA: begin
          if (cs_rise) begin
            state_q <= FG_ST_IDLE;
            err_o   <= 1'b1;
            miso_o  <= 1'b0;
          end else begin
            // rw_q holds "is read" so the tx path is idle for write frames
            // and miso_o stays low.
            if (load_tx_q && rw_q) begin
              tx_q <= cfg_rdata_i;
            end else if (sclk_fall && rw_q) begin
              miso_o <= tx_q[DATA_W-1];
              tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
            end

            if (sclk_rise) begin
              shift_q   <= shift_next[DATA_W-2:0];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == FRAME_LAST) begin
                state_q <= FG_ST_HOLD;
                miso_o  <= 1'b0;
                if (!rw_q) begin
                  if (addr_valid) begin
                    cfg_wr_o   <= 1'b1;
                    cfg_data_o <= shift_next;
                    err_o      <= 1'b0;
                  end else begin
                    err_o <= 1'b1;
                  end
                end
              end
            end
          end
        end

        FG_ST_HOLD: begin
          miso_o <= 1'b0;
          if (cs_rise) begin
            state_q <= FG_ST_IDLE;
          end
        end

        default: begin
          state_q <= FG_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fg_spi_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_fg_spi_cfg_loader
// Self-checking bench for fg_spi_cfg_loader: a directed vector table,
// hand-written sequences for reset-mid-frame and coincident cs/sclk edges,
// then randomized frames predicted by a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_fg_spi_cfg_loader;

  localparam int HALF = 6;  // sclk half period in clk cycles
  localparam logic [7:0] BANK_INIT [7] = '{8'hA0, 8'h05, 8'hC3, 8'h3C, 8'h5A, 8'hE1, 8'h96};

  typedef struct {
    logic [31:0] frame;     // right-aligned, sent MSB first
    int          nbits;
    int          exp_wr;    // expected number of strobe cycles
    logic [2:0]  exp_addr;  // strobe address and held cfg_addr_o (if nbits >= 8)
    logic [7:0]  exp_data;
    logic        exp_err;
    logic        chk_miso;
    logic [7:0]  exp_miso;  // byte seen by the master on rises 9..16
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] cfg_rdata;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_wr;
  logic       busy;
  logic       err;

  fg_spi_cfg_loader #(
    .SYNC_STAGES (2),
    .NUM_REGS    (7),
    .ADDR_W      (3),
    .DATA_W      (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sclk_i      (sclk),
    .cs_n_i      (cs_n),
    .mosi_i      (mosi),
    .miso_o      (miso),
    .cfg_rdata_i (cfg_rdata),
    .cfg_addr_o  (cfg_addr),
    .cfg_data_o  (cfg_data),
    .cfg_wr_o    (cfg_wr),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Register bank stand-in: combinational read mux, writes on the strobe.
  logic [7:0] bank [7];
  logic       bank_init = 1'b1;

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 0; i < 7; i++) bank[i] <= BANK_INIT[i];
    end else if (cfg_wr && cfg_addr < 3'd7) begin
      bank[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    cfg_rdata = 8'h00;
    if (cfg_addr < 3'd7) cfg_rdata = bank[cfg_addr];
  end

  // Strobe monitor, sampled away from the active edge.
  int         wr_cnt = 0;
  logic [2:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;

  always @(negedge clk) begin
    if (cfg_wr) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= cfg_addr;
      last_wr_data <= cfg_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [7:0] model_regs [7];
  logic [2:0] cur_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of one cs window. With simul set, cs_n falls and the first
  // sclk rise happen at the same instant.
  task automatic spi_frame(input logic [31:0] frame, input int nbits, input bit simul,
                           input int id, output logic [7:0] miso_cap);
    int first;
    miso_cap = '0;
    first    = 0;
    if (simul) begin
      mosi = frame[nbits-1];
      cs_n = 1'b0;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk  = 1'b0;
      first = 1;
    end else begin
      cs_n = 1'b0;
    end
    for (int i = first; i < nbits; i++) begin
      mosi = frame[nbits-1-i];
      wait_clk(HALF);
      if (i >= 8 && i < 16) miso_cap = {miso_cap[6:0], miso};
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
      if (i == 15 && nbits > 16) begin
        wait_clk(HALF);
        check($sformatf("vec%0d hold_busy", id), {31'd0, busy}, 32'd0);
      end
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(10);
  endtask

  task automatic run_vec(input vec_t v, input bit simul, input int id);
    int         wr0;
    logic [7:0] mb;
    wr0 = wr_cnt;
    spi_frame(v.frame, v.nbits, simul, id, mb);
    check($sformatf("vec%0d wr_count", id), wr_cnt - wr0, v.exp_wr);
    if (v.exp_wr == 1) begin
      check($sformatf("vec%0d wr_addr", id), {29'd0, last_wr_addr}, {29'd0, v.exp_addr});
      check($sformatf("vec%0d wr_data", id), {24'd0, last_wr_data}, {24'd0, v.exp_data});
      model_regs[v.exp_addr] = v.exp_data;
    end
    if (v.nbits >= 8) begin
      check($sformatf("vec%0d cfg_addr", id), {29'd0, cfg_addr}, {29'd0, v.exp_addr});
      cur_addr = v.exp_addr;
    end
    check($sformatf("vec%0d err", id), {31'd0, err}, {31'd0, v.exp_err});
    check($sformatf("vec%0d busy", id), {31'd0, busy}, 32'd0);
    if (v.chk_miso) check($sformatf("vec%0d miso_byte", id), {24'd0, mb}, {24'd0, v.exp_miso});
  endtask

  function automatic vec_t mk(input logic [31:0] frame, input int nbits, input int exp_wr,
                              input logic [2:0] a, input logic [7:0] d, input logic e,
                              input logic cm, input logic [7:0] m);
    vec_t v;
    v.frame = frame; v.nbits = nbits; v.exp_wr = exp_wr; v.exp_addr = a;
    v.exp_data = d; v.exp_err = e; v.chk_miso = cm; v.exp_miso = m;
    return v;
  endfunction

  vec_t vecs [12];
  logic model_err;

  initial begin
    for (int i = 0; i < 7; i++) model_regs[i] = BANK_INIT[i];
    model_err = 1'b0;

    // Directed table, applied in order (err_o and the bank carry over).
    vecs[0]  = mk(32'h8532,   16, 1, 3'd5, 8'h32, 1'b0, 1'b1, 8'h00); // valid write
    vecs[1]  = mk(32'h0100,   16, 0, 3'd1, 8'h00, 1'b0, 1'b1, 8'h05); // read addr 1
    vecs[2]  = mk(32'h87AA,   16, 0, 3'd7, 8'h00, 1'b1, 1'b1, 8'h00); // invalid addr
    vecs[3]  = mk(32'h8011,   16, 1, 3'd0, 8'h11, 1'b0, 1'b1, 8'h00); // clears err
    vecs[4]  = mk(32'h041F,   11, 0, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00); // abort after 11 bits
    vecs[5]  = mk(32'h8477,   16, 1, 3'd4, 8'h77, 1'b0, 1'b1, 8'h00); // accepted after abort
    vecs[6]  = mk(32'h8249FF, 24, 1, 3'd2, 8'h49, 1'b0, 1'b1, 8'h00); // 8 extra bits
    vecs[7]  = mk(32'h0500,   16, 0, 3'd5, 8'h00, 1'b0, 1'b1, 8'h32); // reads earlier write
    vecs[8]  = mk(32'h0600,   16, 0, 3'd6, 8'h00, 1'b0, 1'b1, 8'h96); // last valid reg
    vecs[9]  = mk(32'h0700,   16, 0, 3'd7, 8'h00, 1'b0, 1'b1, 8'h00); // read past bank
    vecs[10] = mk(32'h7B00,   16, 0, 3'd3, 8'h00, 1'b0, 1'b1, 8'h3C); // reserved bits set
    vecs[11] = mk(32'hF9C4,   16, 1, 3'd1, 8'hC4, 1'b0, 1'b1, 8'h00); // reserved bits set

    // Reset state.
    wait_clk(5);
    check("reset miso", {31'd0, miso}, 32'd0);
    check("reset cfg_addr", {29'd0, cfg_addr}, 32'd0);
    check("reset cfg_data", {24'd0, cfg_data}, 32'd0);
    check("reset cfg_wr", {31'd0, cfg_wr}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    bank_init = 1'b0;
    rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0, i);

    // cs_n fall and first sclk rise together: bit must still be counted.
    run_vec(mk(32'h8356, 16, 1, 3'd3, 8'h56, 1'b0, 1'b1, 8'h00), 1'b1, 100);

    // Reset in the middle of a write frame, with err_o set beforehand.
    run_vec(mk(32'h87AA, 16, 0, 3'd7, 8'h00, 1'b1, 1'b1, 8'h00), 1'b0, 101);
    begin
      logic [15:0] f;
      int          wr0;
      f    = 16'h8123;
      wr0  = wr_cnt;
      cs_n = 1'b0;
      for (int i = 0; i < 12; i++) begin
        mosi = f[15-i];
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
      end
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(2);
      check("midrst miso", {31'd0, miso}, 32'd0);
      check("midrst cfg_addr", {29'd0, cfg_addr}, 32'd0);
      check("midrst cfg_data", {24'd0, cfg_data}, 32'd0);
      check("midrst busy", {31'd0, busy}, 32'd0);
      check("midrst err", {31'd0, err}, 32'd0);
      for (int i = 12; i < 16; i++) begin
        mosi = f[15-i];
        wait_clk(HALF);
        sclk = 1'b1;
        check("midrst tail_busy", {31'd0, busy}, 32'd0);
        wait_clk(HALF);
        sclk = 1'b0;
      end
      wait_clk(HALF);
      cs_n = 1'b1;
      mosi = 1'b0;
      wait_clk(10);
      check("midrst wr_count", wr_cnt - wr0, 32'd0);
      check("midrst err_after", {31'd0, err}, 32'd0);
      cur_addr = 3'd0;
    end
    run_vec(mk(32'h8123, 16, 1, 3'd1, 8'h23, 1'b0, 1'b1, 8'h00), 1'b0, 102);
    model_err = 1'b0;

    // Randomized frames against a frame-level model.
    for (int n = 0; n < 40; n++) begin
      logic        rw;
      logic [2:0]  a;
      logic [3:0]  rsv;
      logic [7:0]  d;
      logic [15:0] f16;
      int          kind, nb;
      vec_t        v;
      rw   = 1'($urandom_range(0, 1));
      a    = 3'($urandom_range(0, 7));
      rsv  = 4'($urandom_range(0, 15));
      d    = 8'($urandom);
      kind = $urandom_range(0, 9);
      f16  = {rw, rsv, a, d};
      if (kind == 0)      nb = $urandom_range(1, 15);
      else if (kind == 1) nb = 16 + $urandom_range(1, 8);
      else                nb = 16;

      v = mk(32'd0, nb, 0, cur_addr, 8'h00, model_err, 1'b0, 8'h00);
      if (nb < 16) begin
        v.frame   = {16'd0, f16} >> (16 - nb);
        v.exp_err = 1'b1;
        if (nb >= 8) v.exp_addr = a;
      end else begin
        v.frame    = ({16'd0, f16} << (nb - 16)) | ($urandom & ((32'd1 << (nb - 16)) - 32'd1));
        v.exp_addr = a;
        v.chk_miso = 1'b1;
        if (rw) begin
          if (a < 3'd7) begin
            v.exp_wr   = 1;
            v.exp_data = d;
            v.exp_err  = 1'b0;
          end else begin
            v.exp_err = 1'b1;
          end
        end else begin
          v.exp_miso = (a < 3'd7) ? model_regs[a] : 8'h00;
        end
      end
      model_err = v.exp_err;
      run_vec(v, 1'b0, 200 + n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
